// File: rtl/wram_arbiter_pkg.sv
// Shared constants and types for the NES WRAM arbiter and its BSRAM.
package wram_arbiter_pkg;

    localparam int unsigned WRAM_AW = 13;
    localparam int unsigned CPU_AW  = 22;
    localparam int unsigned RV_AW   = 23;

    localparam logic [CPU_AW-1:0] CPU_WRAM_BASE = 22'h006000;
    localparam logic [RV_AW-1:0]  RV_WRAM_BASE  = 23'h066000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RV_LO   = 2'd1,
        RV_HI   = 2'd2,
        RV_DONE = 2'd3
    } wram_arb_state_t;

    typedef struct packed {
        logic [WRAM_AW-1:0] addr;
        logic [7:0]         wdata;
        logic               we;
    } cpu_req_t;

    typedef struct packed {
        logic [WRAM_AW-2:0] hw_addr;
        logic [15:0]        wdata;
        logic [1:0]         ds;
        logic               we;
    } rv_req_t;

endpackage

// File: rtl/wram_bsram.sv
// 8 KiB single-port synchronous RAM holding NES WRAM; read data one cycle after address.
module wram_bsram
    import wram_arbiter_pkg::*;
(
    input  logic               i_clk,
    input  logic [WRAM_AW-1:0] i_addr,
    input  logic               i_we,
    input  logic [7:0]         i_wdata,
    output logic [7:0]         o_rdata
);

    localparam int unsigned DEPTH = 2 ** WRAM_AW;

    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_addr] <= i_wdata;
        end
        o_rdata <= mem_q[i_addr];
    end

endmodule

// File: rtl/wram_arbiter.sv
// Byte-wide arbiter sharing the WRAM BSRAM between NES CPU strobes and RISC-V
// toggle-handshake halfword requests; CPU wins unless a WRAM load is in progress.
module wram_arbiter
    import wram_arbiter_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [CPU_AW-1:0]  i_cpu_addr,
    input  logic               i_cpu_read,
    input  logic               i_cpu_write,
    input  logic [7:0]         i_cpu_wdata,
    output logic [7:0]         o_cpu_rdata,
    output logic               o_cpu_hit,
    output logic               o_cpu_drop,
    input  logic [RV_AW-1:0]   i_rv_addr,
    input  logic [15:0]        i_rv_wdata,
    input  logic [1:0]         i_rv_ds,
    input  logic               i_rv_we,
    input  logic               i_rv_req,
    output logic               o_rv_ack,
    output logic [15:0]        o_rv_rdata,
    output logic               o_rv_hit,
    input  logic               i_wram_load_ongoing,
    output logic [WRAM_AW-1:0] o_bsram_addr,
    output logic               o_bsram_we,
    output logic [7:0]         o_bsram_wdata,
    input  logic [7:0]         i_bsram_rdata
);

    wram_arb_state_t state_q;
    cpu_req_t        cpu_q;
    rv_req_t         rv_q;
    logic            pend_q;
    logic            rv_seen_q;
    logic            cpu_rd_q;
    logic            rv_lo_rd_q;

    logic [CPU_AW-1:0] cpu_off;
    logic [RV_AW-1:0]  rv_off;
    logic              rv_lsb_unused;
    logic              cpu_strobe;
    logic              rv_new;
    logic              rv_busy;
    logic              rv_hi_phase;
    logic              cpu_gnt;
    logic              rv_gnt;

    // Window decode: offset from base must fit in the WRAM address width.
    assign cpu_off       = i_cpu_addr - CPU_WRAM_BASE;
    assign rv_off        = i_rv_addr - RV_WRAM_BASE;
    assign rv_lsb_unused = rv_off[0];
    assign o_cpu_hit     = (cpu_off[CPU_AW-1:WRAM_AW] == '0);
    assign o_rv_hit      = (rv_off[RV_AW-1:WRAM_AW] == '0);

    assign cpu_strobe  = (i_cpu_read | i_cpu_write) & o_cpu_hit;
    assign rv_new      = (i_rv_req != rv_seen_q);
    assign rv_busy     = (state_q == RV_LO) || (state_q == RV_HI);
    assign rv_hi_phase = (state_q == RV_HI);
    assign cpu_gnt     = pend_q & (~i_wram_load_ongoing | ~rv_busy);
    assign rv_gnt      = rv_busy & ~cpu_gnt;

    // BSRAM port mux: single winner per cycle, idle drives zero.
    always_comb begin
        o_bsram_addr  = '0;
        o_bsram_we    = 1'b0;
        o_bsram_wdata = '0;
        if (cpu_gnt) begin
            o_bsram_addr  = cpu_q.addr;
            o_bsram_we    = cpu_q.we;
            o_bsram_wdata = cpu_q.wdata;
        end else if (rv_gnt) begin
            o_bsram_addr  = {rv_q.hw_addr, rv_hi_phase};
            o_bsram_we    = rv_q.we & (rv_hi_phase ? rv_q.ds[1] : rv_q.ds[0]);
            o_bsram_wdata = rv_hi_phase ? rv_q.wdata[15:8] : rv_q.wdata[7:0];
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= IDLE;
            cpu_q       <= '0;
            rv_q        <= '0;
            pend_q      <= 1'b0;
            rv_seen_q   <= 1'b0;
            cpu_rd_q    <= 1'b0;
            rv_lo_rd_q  <= 1'b0;
            o_cpu_rdata <= '0;
            o_cpu_drop  <= 1'b0;
            o_rv_ack    <= 1'b0;
            o_rv_rdata  <= '0;
        end else begin
            // One-deep CPU latch; a strobe while occupied is dropped.
            if (cpu_gnt) begin
                pend_q <= 1'b0;
            end
            if (cpu_strobe && !pend_q) begin
                pend_q      <= 1'b1;
                cpu_q.addr  <= cpu_off[WRAM_AW-1:0];
                cpu_q.wdata <= i_cpu_wdata;
                cpu_q.we    <= i_cpu_write;
            end
            o_cpu_drop <= cpu_strobe & pend_q;

            cpu_rd_q   <= cpu_gnt & ~cpu_q.we;
            rv_lo_rd_q <= rv_gnt & (state_q == RV_LO) & ~rv_q.we;
            if (cpu_rd_q) begin
                o_cpu_rdata <= i_bsram_rdata;
            end
            if (rv_lo_rd_q) begin
                o_rv_rdata[7:0] <= i_bsram_rdata;
            end

            // Toggles seen while busy stay pending until the FSM is back in IDLE.
            case (state_q)
                IDLE: begin
                    rv_seen_q <= i_rv_req;
                    if (rv_new && o_rv_hit) begin
                        rv_q.hw_addr <= rv_off[WRAM_AW-1:1];
                        rv_q.wdata   <= i_rv_wdata;
                        rv_q.ds      <= i_rv_ds;
                        rv_q.we      <= i_rv_we;
                        state_q      <= RV_LO;
                    end
                end
                RV_LO: begin
                    if (rv_gnt) begin
                        state_q <= RV_HI;
                    end
                end
                RV_HI: begin
                    if (rv_gnt) begin
                        state_q <= RV_DONE;
                    end
                end
                RV_DONE: begin
                    if (!rv_q.we) begin
                        o_rv_rdata[15:8] <= i_bsram_rdata;
                    end
                    o_rv_ack <= ~o_rv_ack;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wram_arbiter.sv
// Directed bench for wram_arbiter with a byte-memory / expected-write-schedule model.
module tb_wram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [21:0] cpu_addr;
    logic        cpu_read;
    logic        cpu_write;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_hit;
    logic        cpu_drop;
    logic [22:0] rv_addr;
    logic [15:0] rv_wdata;
    logic [1:0]  rv_ds;
    logic        rv_we;
    logic        rv_req;
    logic        rv_ack;
    logic [15:0] rv_rdata;
    logic        rv_hit;
    logic        load;
    logic [12:0] b_addr;
    logic        b_we;
    logic [7:0]  b_wdata;
    logic [7:0]  b_rdata;

    wram_arbiter dut (
        .i_clk               (clk),
        .i_reset             (rst),
        .i_cpu_addr          (cpu_addr),
        .i_cpu_read          (cpu_read),
        .i_cpu_write         (cpu_write),
        .i_cpu_wdata         (cpu_wdata),
        .o_cpu_rdata         (cpu_rdata),
        .o_cpu_hit           (cpu_hit),
        .o_cpu_drop          (cpu_drop),
        .i_rv_addr           (rv_addr),
        .i_rv_wdata          (rv_wdata),
        .i_rv_ds             (rv_ds),
        .i_rv_we             (rv_we),
        .i_rv_req            (rv_req),
        .o_rv_ack            (rv_ack),
        .o_rv_rdata          (rv_rdata),
        .o_rv_hit            (rv_hit),
        .i_wram_load_ongoing (load),
        .o_bsram_addr        (b_addr),
        .o_bsram_we          (b_we),
        .o_bsram_wdata       (b_wdata),
        .i_bsram_rdata       (b_rdata)
    );

    wram_bsram ram (
        .i_clk   (clk),
        .i_addr  (b_addr),
        .i_we    (b_we),
        .i_wdata (b_wdata),
        .o_rdata (b_rdata)
    );

    typedef struct {
        int addr;
        int data;
        int at;
    } wr_t;

    wr_t        exp_wr[$];
    logic [7:0] mem_m [0:8191];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         drops = 0;
    int         mon_idx;
    logic       exp_ack = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic bit cpu_in(input logic [21:0] a);
        return (a >= 22'h006000) && (a < 22'h008000);
    endfunction

    function automatic bit rv_in(input logic [22:0] a);
        return (a >= 23'h066000) && (a < 23'h068000);
    endfunction

    // Per-cycle compare: window flags, and every BSRAM write against the expected schedule.
    always @(negedge clk) begin
        if (rst) begin
            chk("we_in_reset", 32'(b_we), 32'(0));
        end else begin
            chk("cpu_hit", 32'(cpu_hit), 32'(cpu_in(cpu_addr)));
            chk("rv_hit", 32'(rv_hit), 32'(rv_in(rv_addr)));
            if (cpu_drop) drops++;
            if (b_we) begin
                mon_idx = -1;
                foreach (exp_wr[i]) if (exp_wr[i].at == cyc) mon_idx = i;
                if (mon_idx < 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: got addr %0h data %0h, none expected (cycle %0d)",
                             b_addr, b_wdata, cyc);
                end else begin
                    chk("wr_addr", 32'(b_addr), 32'(exp_wr[mon_idx].addr));
                    chk("wr_data", 32'(b_wdata), 32'(exp_wr[mon_idx].data));
                    exp_wr.delete(mon_idx);
                end
            end
            for (int i = exp_wr.size() - 1; i >= 0; i--) begin
                if (exp_wr[i].at < cyc) begin
                    total++;
                    bad++;
                    $display("FAIL missing_write: got none, expected addr %0h data %0h at cycle %0d",
                             exp_wr[i].addr, exp_wr[i].data, exp_wr[i].at);
                    exp_wr.delete(i);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_wr(input logic [21:0] a, input logic [7:0] d, input int lat);
        logic [12:0] off;
        off       = 13'(a - 22'h006000);
        cpu_addr  = a;
        cpu_wdata = d;
        cpu_write = 1'b1;
        if (cpu_in(a)) begin
            exp_wr.push_back('{int'(off), int'(d), cyc + lat});
            mem_m[off] = d;
        end
        step();
        cpu_write = 1'b0;
    endtask

    task automatic cpu_rd(input logic [21:0] a, input logic [7:0] exp, input string nm);
        cpu_addr = a;
        cpu_read = 1'b1;
        step();
        cpu_read = 1'b0;
        step();
        step();
        chk(nm, 32'(cpu_rdata), 32'(exp));
    endtask

    // Issue a request; hi_at = cycle offset of the high-byte write (0 = never lands).
    task automatic rv_go(input logic [22:0] a, input logic [15:0] wd, input logic [1:0] ds,
                         input logic we, input int hi_at);
        logic [12:0] lo;
        lo       = 13'(a - 23'h066000) & 13'h1FFE;
        rv_addr  = a;
        rv_wdata = wd;
        rv_ds    = ds;
        rv_we    = we;
        rv_req   = ~rv_req;
        if (rv_in(a)) begin
            exp_ack = ~exp_ack;
            if (we && ds[0]) begin
                exp_wr.push_back('{int'(lo), int'(wd[7:0]), cyc + 1});
                mem_m[lo] = wd[7:0];
            end
            if (we && ds[1] && hi_at > 0) begin
                exp_wr.push_back('{int'(lo) + 1, int'(wd[15:8]), cyc + hi_at});
                mem_m[lo + 13'd1] = wd[15:8];
            end
        end
    endtask

    task automatic wait_rv(input int c0, input int exp_lat, input string nm);
        int lat;
        lat = -1;
        for (int k = 0; k < 20; k++) begin
            step();
            if (rv_ack === exp_ack) begin
                lat = cyc - c0;
                break;
            end
        end
        chk(nm, 32'(lat), 32'(exp_lat));
    endtask

    task automatic rv_rd(input logic [22:0] a, input logic [15:0] exp, input string nm);
        int c0;
        c0 = cyc;
        rv_go(a, 16'h0000, 2'b11, 1'b0, 0);
        wait_rv(c0, 4, {nm, "_lat"});
        chk(nm, 32'(rv_rdata), 32'(exp));
    endtask

    task automatic hit_pair(input logic [21:0] ca, input logic ce, input logic [22:0] ra, input logic re);
        cpu_addr = ca;
        rv_addr  = ra;
        #1;
        chk("cpu_hit_tbl", 32'(cpu_hit), 32'(ce));
        chk("rv_hit_tbl", 32'(rv_hit), 32'(re));
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        int d0;
        rst = 1'b1;
        cpu_addr = '0; cpu_read = 1'b0; cpu_write = 1'b0; cpu_wdata = '0;
        rv_addr = '0; rv_wdata = '0; rv_ds = '0; rv_we = 1'b0; rv_req = 1'b0; load = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cpu_rdata", 32'(cpu_rdata), 32'(0));
        chk("rst_rv_rdata", 32'(rv_rdata), 32'(0));
        chk("rst_rv_ack", 32'(rv_ack), 32'(0));
        chk("rst_cpu_drop", 32'(cpu_drop), 32'(0));
        chk("rst_bsram", 32'({b_addr, b_we, b_wdata}), 32'(0));
        rst = 1'b0;
        step();

        // CPU write then read of the same byte
        cpu_wr(22'h006005, 8'hA5, 1);
        step();
        cpu_rd(22'h006005, 8'hA5, "cpu_rd_6005");
        step();

        // RV halfword write and readback, then partial (low-byte) write
        c0 = cyc;
        rv_go(23'h066010, 16'h1234, 2'b11, 1'b1, 2);
        wait_rv(c0, 4, "rv_wr_lat");
        step();
        rv_rd(23'h066010, 16'h1234, "rv_rd_1234");
        step();
        c0 = cyc;
        rv_go(23'h066010, 16'hBEEF, 2'b01, 1'b1, 2);
        wait_rv(c0, 4, "rv_ds01_lat");
        step();
        rv_rd(23'h066010, 16'h12EF, "rv_rd_ds01");
        step();

        // CPU steals the RV_HI cycle: RV high byte and ack slip by one
        c0 = cyc;
        rv_go(23'h066020, 16'hCAFE, 2'b11, 1'b1, 3);
        step();
        cpu_wr(22'h007FFF, 8'h55, 1);
        wait_rv(c0, 5, "coll_cpu_first_lat");
        step();
        cpu_rd(22'h007FFF, 8'h55, "coll_cpu_rd");
        rv_rd(23'h066020, 16'hCAFE, "coll_rv_rd");
        step();

        // Same collision during a WRAM load: RV keeps the port, CPU lands after RV_HI
        load = 1'b1;
        c0 = cyc;
        rv_go(23'h066030, 16'hD00D, 2'b11, 1'b1, 2);
        step();
        cpu_wr(22'h007FFE, 8'h66, 2);
        wait_rv(c0, 4, "coll_rv_first_lat");
        load = 1'b0;
        step();
        cpu_rd(22'h007FFE, 8'h66, "coll2_cpu_rd");
        rv_rd(23'h066030, 16'hD00D, "coll2_rv_rd");
        step();

        // Window edges
        hit_pair(22'h005FFF, 1'b0, 23'h065FFF, 1'b0);
        hit_pair(22'h006000, 1'b1, 23'h066000, 1'b1);
        hit_pair(22'h007FFF, 1'b1, 23'h067FFF, 1'b1);
        hit_pair(22'h008000, 1'b0, 23'h068000, 1'b0);
        hit_pair(22'h206000, 1'b0, 23'h000000, 1'b0);

        // Out-of-window accesses: no BSRAM write, ack unchanged, later request still served
        cpu_wr(22'h008000, 8'h99, 1);
        rv_go(23'h068000, 16'h4242, 2'b11, 1'b1, 2);
        repeat (8) step();
        chk("rv_ack_oow", 32'(rv_ack), 32'(exp_ack));
        rv_rd(23'h066010, 16'h12EF, "rv_rd_after_oow");
        step();

        // Model-driven sweep: CPU bytes read back as RV halfwords
        for (int i = 0; i < 4; i++) begin
            cpu_wr(22'h006200 + 22'(2 * i), 8'(i * 17 + 3), 1);
            step();
            cpu_wr(22'h006201 + 22'(2 * i), 8'(i * 29 + 7), 1);
            step();
        end
        for (int i = 0; i < 4; i++) begin
            rv_rd(23'h066200 + 23'(2 * i),
                  {mem_m[13'h0201 + 13'(2 * i)], mem_m[13'h0200 + 13'(2 * i)]}, "sweep_rv_rd");
            step();
        end

        // Back-to-back strobes: second is dropped with a single pulse
        d0 = drops;
        c0 = cyc;
        cpu_addr  = 22'h006100;
        cpu_wdata = 8'h11;
        cpu_write = 1'b1;
        exp_wr.push_back('{'h100, 'h11, c0 + 1});
        mem_m[13'h0100] = 8'h11;
        step();
        chk("drop_c1", 32'(cpu_drop), 32'(0));
        cpu_addr  = 22'h006101;
        cpu_wdata = 8'h22;
        step();
        cpu_write = 1'b0;
        chk("drop_c2", 32'(cpu_drop), 32'(1));
        step();
        chk("drop_c3", 32'(cpu_drop), 32'(0));
        chk("drop_count", 32'(drops - d0), 32'(1));
        cpu_rd(22'h006100, 8'h11, "drop_keep_rd");
        step();

        // Reset while the RV FSM is writing its high byte
        c0 = cyc;
        rv_go(23'h066040, 16'h7788, 2'b11, 1'b1, 0);
        step();
        step();
        rst    = 1'b1;
        rv_req = 1'b0;
        #1;
        chk("rst_we_immediate", 32'(b_we), 32'(0));
        chk("rst_ack_immediate", 32'(rv_ack), 32'(0));
        exp_ack = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        c0 = cyc;
        rv_go(23'h066040, 16'h0000, 2'b11, 1'b0, 0);
        wait_rv(c0, 4, "post_rst_lat");
        chk("post_rst_lo", 32'(rv_rdata[7:0]), 32'(8'h88));
        step();
        step();

        chk("writes_left", 32'(exp_wr.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
